// File: rtl/alu_serial.sv
// alu_serial: multi-cycle digit-serial ALU. It applies XOR / OR / AND / ADD,
// with optional per-operand inversion and a carry-in, to N-bit operands,
// K bits per clock, least significant digit first. Only one operation is
// in flight at a time, under a start/busy/done handshake.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | processing one K-bit digit per cycle, N/K cycles in total
//   DONE   | one-cycle result pulse; start here chains straight into RUN
//
// Parameters
//   N      operand/result width (>= 2)
//   K      bits per cycle (N % K == 0)
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  request, sampled in IDLE and DONE only
//   A, B   operands, captured on an accepted start
//   Cin    carry into bit 0, captured on an accepted start
//   Op     00 XOR, 01 OR, 10 AND, 11 ADD, captured on an accepted start
//   invA   invert A before the operation
//   invB   invert B before the operation
//   busy   high while in RUN
//   done   one-cycle pulse; Out and the flags are valid
//   Out    result, held until the next operation completes
//   Cout   carry out of bit N-1 for ADD, 0 for other ops
//   Zero   Out == 0
//   Ofl    signed overflow for ADD (only when ALU_SERIAL_OFL_EN is defined)
//
// Build option
//   ALU_SERIAL_OFL_EN  adds the Ofl port and its sign-tracking logic.

module alu_serial #(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [1:0]   Op,
  input  logic         invA,
  input  logic         invB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Out,
  output logic         Cout,
  output logic         Zero
`ifdef ALU_SERIAL_OFL_EN
  ,
  output logic         Ofl
`endif
);

  localparam int DIGITS = N / K;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [1:0]    op_q;
  logic          carry_q;
  logic [N-1:0]  res_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  out_q;
  logic          cout_q;
  logic          zero_q;

  logic [K-1:0]  digit_d;
  logic          carry_d;
  logic [N-1:0]  res_d;
  logic          zero_d;
  logic          c_chain;
  logic          ai;
  logic          bi;

  // K bit-slices rippled within the cycle; the carry flop links digits.
  always_comb begin
    digit_d = '0;
    c_chain = carry_q;
    ai      = 1'b0;
    bi      = 1'b0;
    for (int i = 0; i < K; i++) begin
      ai = a_q[i];
      bi = b_q[i];
      case (op_q)
        OP_XOR:  digit_d[i] = ai ^ bi;
        OP_OR:   digit_d[i] = ai | bi;
        OP_AND:  digit_d[i] = ai & bi;
        default: begin
          digit_d[i] = ai ^ bi ^ c_chain;
          c_chain    = (ai & bi) | (c_chain & (ai ^ bi));
        end
      endcase
    end
    carry_d = (op_q == OP_ADD) ? c_chain : 1'b0;
  end

  // New digit enters at the top; after DIGITS shifts the result is aligned.
  assign res_d  = (res_q >> K) | (N'(digit_d) << (N - K));
  assign zero_d = ~|res_d;

`ifdef ALU_SERIAL_OFL_EN
  logic ofl_q;
  logic ofl_d;

  // On the final digit the operand sign bits sit in slice K-1.
  assign ofl_d = (op_q == OP_ADD) && (a_q[K-1] == b_q[K-1]) &&
                 (res_d[N-1] != a_q[K-1]);
  assign Ofl   = ofl_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_XOR;
      carry_q <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ALU_SERIAL_OFL_EN
      ofl_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            a_q     <= A ^ {N{invA}};
            b_q     <= B ^ {N{invB}};
            op_q    <= Op;
            carry_q <= Cin;
            res_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> K;
          b_q     <= b_q >> K;
          carry_q <= carry_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= res_d;
            cout_q  <= carry_d;
            zero_q  <= zero_d;
`ifdef ALU_SERIAL_OFL_EN
            ofl_q   <= ofl_d;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Out  = out_q;
  assign Cout = cout_q;
  assign Zero = zero_q;

endmodule
